// File: rtl/max7219_pkg.sv
// Shared constants and word builder for the MAX7219 two-device chain transmitter.
package max7219_pkg;

  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCAN      = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam int unsigned INIT_WORDS = 5;
  localparam int unsigned ROW_WORDS  = 8;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_SHIFT,
    SPI_LATCH
  } spi_state_e;

  // One device's 16-bit register write.
  function automatic logic [15:0] mk_half(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_spi_word.sv
// Shifts one 32-bit chain word MSB first with a divided serial clock, then pulses LOAD.
module max7219_spi_word #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [31:0] word_in,
  output logic        word_done_c,
  output logic        max_din,
  output logic        max_clk,
  output logic        max_load
);
  import max7219_pkg::*;

  localparam int unsigned     CW       = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(CLK_DIV);

  spi_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   sh_q, sh_d;
  logic          max_din_q, max_din_d;
  logic          max_clk_q, max_clk_d;
  logic          max_load_q, max_load_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SPI_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      max_din_q  <= 1'b0;
      max_clk_q  <= 1'b0;
      max_load_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      max_din_q  <= max_din_d;
      max_clk_q  <= max_clk_d;
      max_load_q <= max_load_d;
    end
  end

  // Pin values are decoded from the next state so they line up with state_q.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    word_done_c = 1'b0;

    unique case (state_q)
      SPI_IDLE: begin
        if (go) begin
          state_d = SPI_SHIFT;
          sh_d    = word_in;
          bit_d   = 5'd31;
          cnt_d   = '0;
        end
      end
      SPI_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 5'd0) begin
            state_d = SPI_LATCH;
          end else begin
            bit_d = bit_q - 5'd1;
            sh_d  = {sh_q[30:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SPI_LATCH: begin
        if (cnt_q == CNT_LAST) begin
          word_done_c = 1'b1;
          cnt_d       = '0;
          if (go) begin
            state_d = SPI_SHIFT;
            sh_d    = word_in;
            bit_d   = 5'd31;
          end else begin
            state_d = SPI_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = SPI_IDLE;
    endcase

    max_load_d = (state_d != SPI_SHIFT);
    max_clk_d  = (state_d == SPI_SHIFT) && (cnt_d >= CNT_HALF);
    max_din_d  = (state_d == SPI_SHIFT) && sh_d[31];
  end

  assign max_din  = max_din_q;
  assign max_clk  = max_clk_q;
  assign max_load = max_load_q;

endmodule

// File: rtl/max7219_frame_tx.sv
// Snapshots a 128-bit pixel frame and streams config plus row words to two chained MAX7219s.
module max7219_frame_tx #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         init_req,
  input  logic [127:0] frame,
  output logic         busy,
  output logic         done,
  output logic         max_din,
  output logic         max_clk,
  output logic         max_load
);
  import max7219_pkg::*;

  localparam logic [3:0] N_INIT_FRAME = 4'(INIT_WORDS + ROW_WORDS);
  localparam logic [3:0] N_ROW_FRAME  = 4'(ROW_WORDS);

  logic [127:0] shadow_q, shadow_d;
  logic         init_pending_q, init_pending_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [3:0]   word_idx_q, word_idx_d;
  logic [3:0]   n_words_q, n_words_d;
  logic         init_now;
  logic         go_c;
  logic [31:0]  word_c;
  logic         word_done_c;

  // Word idx of a frame: config words first when with_init, then rows 0..7.
  function automatic logic [31:0] word_for(input logic [3:0] idx, input logic with_init,
                                           input logic [127:0] frm);
    logic [15:0] cfg;
    logic [2:0]  row;
    logic [3:0]  addr;
    logic [6:0]  lo;
    logic [31:0] w;
    unique case (idx)
      4'd0:    cfg = mk_half(ADDR_DECODE, 8'h00);
      4'd1:    cfg = mk_half(ADDR_INTENSITY, {4'h0, INTENSITY});
      4'd2:    cfg = mk_half(ADDR_SCAN, 8'h07);
      4'd3:    cfg = mk_half(ADDR_SHUTDOWN, 8'h01);
      default: cfg = mk_half(ADDR_TEST, 8'h00);
    endcase
    row  = with_init ? 3'(idx - 4'(INIT_WORDS)) : idx[2:0];
    addr = ADDR_DIGIT0 + {1'b0, row};
    lo   = {1'b0, row, 3'b000};
    if (with_init && (idx < 4'(INIT_WORDS))) begin
      w = {cfg, cfg};
    end else begin
      w = {mk_half(addr, frm[7'd64 + lo +: 8]), mk_half(addr, frm[lo +: 8])};
    end
    return w;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q       <= '0;
      init_pending_q <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      word_idx_q     <= '0;
      n_words_q      <= '0;
    end else begin
      shadow_q       <= shadow_d;
      init_pending_q <= init_pending_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      word_idx_q     <= word_idx_d;
      n_words_q      <= n_words_d;
    end
  end

  always_comb begin
    shadow_d       = shadow_q;
    init_pending_d = init_pending_q | init_req;
    busy_d         = busy_q;
    done_d         = 1'b0;
    word_idx_d     = word_idx_q;
    n_words_d      = n_words_q;
    init_now       = init_pending_q | init_req;
    go_c           = 1'b0;
    word_c         = '0;

    if (!busy_q) begin
      if (start) begin
        shadow_d       = frame;
        n_words_d      = init_now ? N_INIT_FRAME : N_ROW_FRAME;
        word_idx_d     = '0;
        init_pending_d = 1'b0;
        busy_d         = 1'b1;
        go_c           = 1'b1;
        word_c         = word_for(4'd0, init_now, frame);
      end
    end else if (word_done_c) begin
      if (word_idx_q == n_words_q - 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        word_idx_d = word_idx_q + 4'd1;
        go_c       = 1'b1;
        word_c     = word_for(word_idx_q + 4'd1, n_words_q == N_INIT_FRAME, shadow_q);
      end
    end
  end

  max7219_spi_word #(
    .CLK_DIV (CLK_DIV)
  ) u_spi_word (
    .clk         (clk),
    .rst         (rst),
    .go          (go_c),
    .word_in     (word_c),
    .word_done_c (word_done_c),
    .max_din     (max_din),
    .max_clk     (max_clk),
    .max_load    (max_load)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_max7219_frame_tx.sv
// Randomised frame bench for max7219_frame_tx with a shift monitor and a word-list reference model.
module tb_max7219_frame_tx;

  localparam int unsigned CLK_DIV   = 2;
  localparam logic [3:0]  INTEN     = 4'h8;
  localparam int          WORD_CYC  = 66 * CLK_DIV;
  localparam int          LIMIT     = 13 * WORD_CYC + 50;

  localparam int M_JITTER = 1;
  localparam int M_STRAY  = 2;
  localparam int M_INIT   = 4;
  localparam int M_HOLD   = 8;
  localparam int M_PRE    = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         init_req = 1'b0;
  logic [127:0] frame = '0;
  logic         busy, done, max_din, max_clk, max_load;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit m_init_pend = 1'b1;

  logic [31:0] got_q[$];
  logic        prev_clk = 1'b0;
  logic        prev_load = 1'b1;
  logic [31:0] sr = '0;
  int          nbits = 0;

  max7219_frame_tx #(
    .CLK_DIV   (CLK_DIV),
    .INTENSITY (INTEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .init_req (init_req),
    .frame    (frame),
    .busy     (busy),
    .done     (done),
    .max_din  (max_din),
    .max_clk  (max_clk),
    .max_load (max_load)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected chain word i of a frame, derived from the register map.
  function automatic logic [31:0] model_word(input int i, input bit wi, input logic [127:0] f);
    int cfg_addr[5];
    int cfg_data[5];
    int r;
    logic [15:0] h, far_h, near_h;
    cfg_addr = '{9, 10, 11, 12, 15};
    cfg_data = '{0, int'(INTEN), 7, 1, 0};
    if (wi && i < 5) begin
      h = 16'(cfg_addr[i] * 256 + cfg_data[i]);
      return {h, h};
    end
    r = wi ? i - 5 : i;
    far_h  = 16'((r + 1) * 256 + int'(f[64 + 8 * r +: 8]));
    near_h = 16'((r + 1) * 256 + int'(f[8 * r +: 8]));
    return {far_h, near_h};
  endfunction

  // Shift monitor: device-side view, data taken on serial clock rise, word on LOAD rise.
  always @(negedge clk) begin
    if (rst) begin
      prev_clk  = 1'b0;
      prev_load = 1'b1;
      nbits     = 0;
    end else begin
      if (!max_load && prev_load) nbits = 0;
      if (max_clk && !prev_clk) begin
        sr = {sr[30:0], max_din};
        nbits++;
      end
      if (max_load && !prev_load) begin
        got_q.push_back(sr);
        check("word_bits", 32'(nbits), 32'd32);
        nbits = 0;
      end
      prev_clk  = max_clk;
      prev_load = max_load;
    end
  end

  task automatic do_frame(input logic [127:0] f, input int mode);
    logic [127:0] acc;
    bit           exp_init;
    int           n, t0, busy_low;
    bit           seen_done;
    got_q.delete();
    if ((mode & M_PRE) == 0) begin
      @(negedge clk);
      frame = f;
      start = 1'b1;
    end
    exp_init    = m_init_pend;
    m_init_pend = 1'b0;
    acc         = frame;
    n           = exp_init ? 13 : 8;
    @(negedge clk);
    check("accept_busy", 32'(busy), 32'd1);
    t0 = cyc;
    if ((mode & M_HOLD) == 0) start = 1'b0;
    busy_low  = 0;
    seen_done = 1'b0;
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge clk);
      if (done) begin
        seen_done = 1'b1;
        check("done_busy", 32'(busy), 32'd0);
        check("frame_len", 32'(cyc - t0), 32'(n * WORD_CYC));
        if ((mode & M_HOLD) == 0) start = 1'b0;
        break;
      end
      if (!busy) busy_low++;
      if ((mode & M_JITTER) != 0) frame = {$urandom, $urandom, $urandom, $urandom};
      if ((mode & M_STRAY) != 0) start = ($urandom_range(0, 3) == 0);
      if ((mode & M_INIT) != 0) begin
        if (c == 100) begin
          init_req    = 1'b1;
          m_init_pend = 1'b1;
        end else begin
          init_req = 1'b0;
        end
      end
    end
    check("done_seen", 32'(seen_done), 32'd1);
    check("busy_low", 32'(busy_low), 32'd0);
    check("word_count", 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("word%0d", i), got_q[i], model_word(i, exp_init, acc));
  endtask

  initial begin
    logic [127:0] f;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clk", 32'(max_clk), 32'd0);
    check("rst_load", 32'(max_load), 32'd1);
    check("rst_din", 32'(max_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    do_frame('0, 0);
    check("t1_w0", got_q[0], 32'h0900_0900);
    check("t1_w1", got_q[1], 32'h0A08_0A08);
    check("t1_w5", got_q[5], 32'h0100_0100);
    check("t1_w12", got_q[12], 32'h0800_0800);

    f = '0;
    f[127:120] = 8'hA5;
    f[7:0]     = 8'h3C;
    do_frame(f, 0);
    check("t2_w0", got_q[0], 32'h0100_013C);
    check("t2_w7", got_q[7], 32'h08A5_0800);

    do_frame({$urandom, $urandom, $urandom, $urandom}, M_STRAY);

    f = {$urandom, $urandom, $urandom, $urandom};
    do_frame(f, M_HOLD);
    do_frame(f, M_PRE);

    do_frame({$urandom, $urandom, $urandom, $urandom}, M_JITTER);

    do_frame({$urandom, $urandom, $urandom, $urandom}, M_INIT);
    do_frame({$urandom, $urandom, $urandom, $urandom}, 0);

    // Abort during the high phase of bit 17 in word 3.
    got_q.delete();
    @(negedge clk);
    frame = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_init_pend = 1'b0;
    repeat (3 * WORD_CYC + 14 * 2 * CLK_DIV + CLK_DIV) @(negedge clk);
    check("pre_rst_words", 32'(got_q.size()), 32'd3);
    check("pre_rst_clk", 32'(max_clk), 32'd1);
    check("pre_rst_load", 32'(max_load), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort_load", 32'(max_load), 32'd1);
    check("abort_clk", 32'(max_clk), 32'd0);
    check("abort_din", 32'(max_din), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    m_init_pend = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_frame({$urandom, $urandom, $urandom, $urandom}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
